// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic-unit sweep checker: opcode encodings
// and the sweep FSM state type.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_ref_model.sv
// Combinational golden model of the arithmetic unit. All results wrap modulo
// 2^WIDTH; a disabled unit reads as zero.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  input  logic             enable,
  output logic [WIDTH-1:0] expected
);

  // Select the expected result for the current opcode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    expected = '0;
    if (enable) begin
      case (s)
        OP_ADD:  expected = a + b;
        OP_SUB:  expected = a - b;
        OP_MUL:  expected = a * b;
        OP_AND:  expected = a & b;
        default: expected = '0;
      endcase
    end
  end

endmodule : alu_ref_model

// File: rtl/alu_sweep_checker.sv
// Exhaustive stimulus/check engine for the arithmetic unit. Walks every
// {en_n, s, a, b} vector, holds each for SETTLE cycles plus a check cycle,
// compares the unit's result with the golden model and reports the outcome.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter  int WIDTH  = 2,
  parameter  int SETTLE = 1,
  localparam int IDXW   = 2*WIDTH + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [1:0]        s,
  output logic              enable,
  input  logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDXW:0]     err_count,
  output logic [IDXW-1:0]   first_fail_idx
);

  // Settle counter only needs to reach SETTLE-1.
  localparam int              CNTW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
  localparam logic [IDXW-1:0] IDX_LAST    = '1;
  localparam logic [IDXW:0]   ERR_MAX     = '1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;
  logic [IDXW:0]     err_q,   err_d;
  logic [IDXW-1:0]   ffi_q,   ffi_d;
  logic              pass_q,  pass_d;
  logic [WIDTH-1:0]  a_q,     a_d;
  logic [WIDTH-1:0]  b_q,     b_d;
  logic [1:0]        s_q,     s_d;
  logic              en_q,    en_d;

  logic [WIDTH-1:0]  expected;
  logic              mismatch;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (a_q),
    .b        (b_q),
    .s        (s_q),
    .enable   (en_q),
    .expected (expected)
  );

  // The model sees the same registered vector that drives the unit.
  assign mismatch = (result != expected);

  // Next-state logic: sweep sequencing, counters and the registered vector.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          pass_d  = 1'b0;
        end
      end

      APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (err_q == '0) ffi_d = idx_q;
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          // Uses the updated count so a failure on the final vector counts.
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end

      default: state_d = IDLE;
    endcase

    // Vector fields are decoded from the index that will be live next cycle,
    // so the outputs change on the same edge as the state.
    a_d  = '0;
    b_d  = '0;
    s_d  = '0;
    en_d = 1'b0;
    if (state_d == APPLY || state_d == CHECK) begin
      b_d  = idx_d[WIDTH-1:0];
      a_d  = idx_d[2*WIDTH-1:WIDTH];
      s_d  = idx_d[2*WIDTH+1:2*WIDTH];
      en_d = ~idx_d[IDXW-1];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      en_q    <= en_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign s              = s_q;
  assign enable         = en_q;
  assign busy           = (state_q == APPLY) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule : alu_sweep_checker
